// File: rtl/uart_image_receiver.sv
// UART 8N1 receiver that packs 9-byte groups into three 24-bit words
// and drives the shared write port of the input line memories.
module uart_image_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_WORDS    = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] address,
  output logic [23:0] din1,
  output logic [23:0] din2,
  output logic [23:0] din3,
  output logic        wr_en,
  output logic        transfer_done,
  output logic        frame_error,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LAST = 16'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, sh_n;
  logic [3:0]    k;
  logic          rx_m, rx_s, rx_d;
  logic          byte_ok, ferr;

  // rx_d is one cycle behind rx_s for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bit_n   = bit_idx;
    sh_n    = shreg;
    byte_ok = 1'b0;
    ferr    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (!transfer_done && rx_d && !rx_s)
          state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          sh_n  = {rx_s, shreg[7:1]};
          bit_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7)
            state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL) begin
          cnt_n   = '0;
          state_n = IDLE;
          byte_ok = rx_s;
          ferr    = !rx_s;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address       <= '0;
      din1          <= '0;
      din2          <= '0;
      din3          <= '0;
      wr_en         <= 1'b0;
      transfer_done <= 1'b0;
      frame_error   <= 1'b0;
      k             <= '0;
    end else begin
      frame_error <= ferr;
      wr_en       <= 1'b0;
      if (byte_ok && !transfer_done) begin
        unique case (k)
          4'd0: din1[23:16] <= shreg;
          4'd1: din1[15:8]  <= shreg;
          4'd2: din1[7:0]   <= shreg;
          4'd3: din2[23:16] <= shreg;
          4'd4: din2[15:8]  <= shreg;
          4'd5: din2[7:0]   <= shreg;
          4'd6: din3[23:16] <= shreg;
          4'd7: din3[15:8]  <= shreg;
          default: din3[7:0] <= shreg;
        endcase
        if (k == 4'd8) begin
          k     <= '0;
          wr_en <= 1'b1;
        end else begin
          k <= k + 1'b1;
        end
      end
      // address advances after the write; the last word latches done
      if (wr_en) begin
        if (address == LAST)
          transfer_done <= 1'b1;
        else
          address <= address + 1'b1;
      end
    end
  end

endmodule
